// File: rtl/calc_scheduler.sv
// calc_scheduler
//   Shares one iterative divider between the current-speed quotient (started
//   by each reed event) and the average-speed quotient (started once per
//   second). Operands are snapshotted when the event arrives. Requests are
//   granted round-robin. The block drives the divider start/done handshake,
//   then saturates the quotient and registers it for the display mux.
//
//   Optional feature macro: MAX_TRACK_EN
//     defined   : max_speed tracks the largest committed speed until RESET
//     undefined : max_speed is tied to zero
//
// Ports
//   CLK        in   1   clock, 2048 Hz
//   RESET      in   1   synchronous, active-high
//   reed_evt   in   1   pulse, wheel revolution completed
//   stop_evt   in   1   pulse, bike fell below minimum speed
//   sec_tick   in   1   pulse, once per second
//   circ       in   8   wheel circumference, cm
//   reed_clks  in   16  clocks between the last two reed pulses
//   distance   in   32  trip distance, cm
//   triptime   in   32  trip time, clocks
//   div_start  out  1   divider start strobe
//   div_num    out  DW  dividend, held from div_start until div_done
//   div_den    out  DW  divisor, held from div_start until div_done
//   div_done   in   1   pulse, div_quot valid
//   div_quot   in   DW  quotient
//   speed      out  8   current speed, km/h
//   avg_speed  out  14  average speed, 0.1 km/h
//   max_speed  out  8   maximum speed, km/h
//   busy       out  1   FSM not in IDLE
//
// States
//   IDLE  | waiting for a pending request; grants one when any is pending
//   ISSUE | div_start asserted for one cycle
//   WAIT  | divider running, waiting for div_done
//   WRITE | commit the saturated result to its output register

module calc_scheduler #(
    parameter int DW      = 40,
    parameter int SPD_K   = 4719,
    parameter int SPD_SH  = 6,
    parameter int AVG_K   = 737,
    parameter int SPD_MAX = 99,
    parameter int AVG_MAX = 9999
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          reed_evt,
    input  logic          stop_evt,
    input  logic          sec_tick,
    input  logic [7:0]    circ,
    input  logic [15:0]   reed_clks,
    input  logic [31:0]   distance,
    input  logic [31:0]   triptime,
    output logic          div_start,
    output logic [DW-1:0] div_num,
    output logic [DW-1:0] div_den,
    input  logic          div_done,
    input  logic [DW-1:0] div_quot,
    output logic [7:0]    speed,
    output logic [13:0]   avg_speed,
    output logic [7:0]    max_speed,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

    localparam logic [DW-1:0] SPD_MAX_W = DW'(SPD_MAX);
    localparam logic [DW-1:0] AVG_MAX_W = DW'(AVG_MAX);

    state_t        state, state_nxt;

    logic          spd_pend, avg_pend;
    logic [DW-1:0] spd_num, spd_den;
    logic [DW-1:0] avg_num, avg_den;

    // rr_avg = 1 when the average request has priority on a tie
    logic          rr_avg;
    // request currently in service (1 = average)
    logic          cur_avg;
    // speed result in flight was invalidated by stop_evt
    logic          discard;
    logic [DW-1:0] res;

    logic          grant, grant_avg, grant_zero;
    logic [7:0]    spd_sat;
    logic [13:0]   avg_sat;
    logic          spd_commit;

    assign busy     = (state != IDLE);
    assign spd_sat  = (res > SPD_MAX_W) ? 8'(SPD_MAX)  : res[7:0];
    assign avg_sat  = (res > AVG_MAX_W) ? 14'(AVG_MAX) : res[13:0];
    // stop_evt in the commit cycle still wins over the divider result
    assign spd_commit = (state == WRITE) && !cur_avg && !discard && !stop_evt;

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_avg  = 1'b0;
        grant_zero = 1'b0;
        div_start  = 1'b0;
        case (state)
            IDLE: begin
                if (spd_pend || avg_pend) begin
                    grant      = 1'b1;
                    grant_avg  = avg_pend && (!spd_pend || rr_avg);
                    grant_zero = grant_avg ? (avg_den == '0) : (spd_den == '0);
                    // a zero divisor never reaches the divider
                    state_nxt  = grant_zero ? WRITE : ISSUE;
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (div_done) state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            spd_pend  <= 1'b0;
            avg_pend  <= 1'b0;
            spd_num   <= '0;
            spd_den   <= '0;
            avg_num   <= '0;
            avg_den   <= '0;
            rr_avg    <= 1'b0;
            cur_avg   <= 1'b0;
            discard   <= 1'b0;
            res       <= '0;
            div_num   <= '0;
            div_den   <= '0;
            speed     <= '0;
            avg_speed <= '0;
        end else begin
            state <= state_nxt;

            // a new event outranks the grant that clears its pending flag
            if (stop_evt) begin
                spd_pend <= 1'b0;
            end else if (reed_evt) begin
                spd_pend <= 1'b1;
                spd_num  <= DW'(circ) * DW'(SPD_K);
                spd_den  <= DW'(reed_clks) << SPD_SH;
            end else if (grant && !grant_avg) begin
                spd_pend <= 1'b0;
            end

            if (sec_tick) begin
                avg_pend <= 1'b1;
                avg_num  <= DW'(distance) * DW'(AVG_K);
                avg_den  <= DW'(triptime);
            end else if (grant && grant_avg) begin
                avg_pend <= 1'b0;
            end

            if (grant) begin
                cur_avg <= grant_avg;
                rr_avg  <= !grant_avg;
                div_num <= grant_avg ? avg_num : spd_num;
                div_den <= grant_avg ? avg_den : spd_den;
                res     <= '0;
                discard <= stop_evt && !grant_avg;
            end else if (stop_evt && busy && !cur_avg) begin
                discard <= 1'b1;
            end

            if ((state == WAIT) && div_done) res <= div_quot;

            if (stop_evt)        speed <= '0;
            else if (spd_commit) speed <= spd_sat;

            if ((state == WRITE) && cur_avg) avg_speed <= avg_sat;
        end
    end

`ifdef MAX_TRACK_EN
    logic [7:0] max_q;

    always_ff @(posedge CLK) begin
        if (RESET)                              max_q <= '0;
        else if (spd_commit && (spd_sat > max_q)) max_q <= spd_sat;
    end

    assign max_speed = max_q;
`else
    assign max_speed = 8'd0;
`endif

endmodule
